// File: rtl/state_readout_if.sv
// Probability stream from state_readout to the host/readout path.
// The producer holds every field stable until prob_valid && prob_ready.
interface state_readout_if #(
  parameter int unsigned AW = 4
) ();
  logic          prob_valid;
  logic          prob_ready;
  logic [AW-1:0] prob_idx;
  logic [31:0]   prob_data;
  logic          prob_last;

  modport master (
    output prob_valid, prob_idx, prob_data, prob_last,
    input  prob_ready
  );

  modport slave (
    input  prob_valid, prob_idx, prob_data, prob_last,
    output prob_ready
  );
endinterface

// File: rtl/state_readout.sv
// Walks the state-vector memory, streams |amp|^2 per basis index, and tracks the total and the argmax.
// Define READOUT_NORM_CHECK_EN to flag a total probability more than NORM_TOL away from 1.0 (2^28).
module state_readout #(
  parameter int unsigned N_QUBITS = 4
`ifdef READOUT_NORM_CHECK_EN
  , parameter int unsigned NORM_TOL = 32'd65536
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(1 << N_QUBITS)-1:0]       mem_addr,
  input  logic signed [15:0]                     mem_rd_r,
  input  logic signed [15:0]                     mem_rd_i,
  state_readout_if.master                        prob,
  output logic [32+$clog2(1 << N_QUBITS)-1:0]    prob_sum,
  output logic [$clog2(1 << N_QUBITS)-1:0]       max_idx,
  output logic                                   norm_err
);

  localparam int unsigned DIM = 1 << N_QUBITS;
  localparam int unsigned AW  = $clog2(DIM);
  localparam int unsigned SW  = 32 + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_EMIT,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] idx_q,     idx_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          valid_q,   valid_d;
  logic          last_q,    last_d;
  logic [AW-1:0] pidx_q,    pidx_d;
  logic [31:0]   pdata_q,   pdata_d;
  logic [SW-1:0] sum_q,     sum_d;
  logic [AW-1:0] max_idx_q, max_idx_d;
  logic [31:0]   max_val_q, max_val_d;

  // Squares are signed 32-bit and non-negative; their sum peaks at exactly 2^31.
  logic signed [31:0] re_w, im_w, re_sq, im_sq;
  logic [31:0]        prob_c;

  assign re_w   = 32'(mem_rd_r);
  assign im_w   = 32'(mem_rd_i);
  assign re_sq  = re_w * re_w;
  assign im_sq  = im_w * im_w;
  assign prob_c = $unsigned(re_sq) + $unsigned(im_sq);

  logic start_acc_c;
  logic handshake_c;
  logic fin_entry_c;

  assign start_acc_c = (state_q == S_IDLE) && start;
  assign handshake_c = (state_q == S_EMIT) && valid_q && prob.prob_ready;
  assign fin_entry_c = handshake_c && (idx_q == LAST_IDX);

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pidx_q    <= '0;
      pdata_q   <= '0;
      sum_q     <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      pidx_q    <= pidx_d;
      pdata_q   <= pdata_d;
      sum_q     <= sum_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_CALC;
      S_CALC:  state_d = S_EMIT;
      S_EMIT:  if (handshake_c) state_d = (idx_q == LAST_IDX) ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; terminal check precedes the increment so idx never wraps.
  always_comb begin
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    last_d    = last_q;
    pidx_d    = pidx_q;
    pdata_d   = pdata_q;
    sum_d     = sum_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc_c) begin
          idx_d     = '0;
          sum_d     = '0;
          max_idx_d = '0;
          max_val_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_CALC: begin
        pdata_d = prob_c;
        pidx_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        valid_d = 1'b1;
        sum_d   = sum_q + SW'(prob_c);
        if (prob_c > max_val_q) begin
          max_val_d = prob_c;
          max_idx_d = idx_q;
        end
      end
      S_EMIT: begin
        if (handshake_c) begin
          valid_d = 1'b0;
          if (fin_entry_c) done_d = 1'b1;
          else             idx_d  = idx_q + AW'(1);
        end
      end
      S_FIN:   busy_d = 1'b0;
      default: ;
    endcase
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_addr        = idx_q;
  assign prob.prob_valid = valid_q;
  assign prob.prob_idx   = pidx_q;
  assign prob.prob_data  = pdata_q;
  assign prob.prob_last  = last_q;
  assign prob_sum        = sum_q;
  assign max_idx         = max_idx_q;

`ifdef READOUT_NORM_CHECK_EN
  localparam logic [SW-1:0] ONE_P = SW'(64'h1000_0000);

  logic [SW-1:0] diff_c;
  logic          norm_q;

  assign diff_c = (sum_q >= ONE_P) ? (sum_q - ONE_P) : (ONE_P - sum_q);

  // Evaluated on the final sum as FIN is entered, so the flag is valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n)           norm_q <= 1'b0;
    else if (start_acc_c) norm_q <= 1'b0;
    else if (fin_entry_c) norm_q <= (diff_c > SW'(NORM_TOL));
  end

  assign norm_err = norm_q;
`else
  assign norm_err = 1'b0;
`endif

endmodule

// File: tb/tb_state_readout.sv
// Scoreboard bench for state_readout: stimulus queues expected words, a negedge monitor pops and compares.
module tb_state_readout;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               busy, done, norm_err;
  logic [3:0]         mem_addr, max_idx;
  logic signed [15:0] mem_rd_r, mem_rd_i;
  logic [35:0]        prob_sum;

  state_readout_if #(.AW(4)) pif ();

  state_readout dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rd_r (mem_rd_r),
    .mem_rd_i (mem_rd_i),
    .prob     (pif),
    .prob_sum (prob_sum),
    .max_idx  (max_idx),
    .norm_err (norm_err)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem_r [16];
  logic signed [15:0] mem_i [16];

  always @(posedge clk) begin
    mem_rd_r <= mem_r[mem_addr];
    mem_rd_i <= mem_i[mem_addr];
  end

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: compare each accepted word and check that a stalled word stays stable.
  word_t held;
  bit    hold_f = 1'b0;
  always @(negedge clk) begin
    word_t got;
    got = '{idx: pif.prob_idx, data: pif.prob_data, last: pif.prob_last};
    if (!pif.prob_valid) hold_f = 1'b0;
    else begin
      if (hold_f) chk("stall_hold", 64'(got), 64'(held));
      if (pif.prob_ready) begin
        hold_f = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_word", 64'(got), 64'hFFFF_FFFF);
        else chk($sformatf("word_%0d", got.idx), 64'(got), 64'(exp_q.pop_front()));
      end else begin
        hold_f = 1'b1;
        held   = got;
      end
    end
  end

  function automatic logic [31:0] prob_of(input logic signed [15:0] r, input logic signed [15:0] i);
    longint lr, li;
    lr = longint'(r);
    li = longint'(i);
    return 32'(lr * lr + li * li);
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 16; k++) begin
      mem_r[k] = '0;
      mem_i[k] = '0;
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 16; k++)
      exp_q.push_back('{idx: 4'(k), data: prob_of(mem_r[k], mem_i[k]), last: (k == 15)});
  endtask

  task automatic do_run(input string nm, input int stall_idx, input int stall_n, input int extra_start,
                        input int exp_done, input logic [35:0] exp_sum, input logic [3:0] exp_max,
                        input logic exp_norm);
    int cnt, first_v, done_at, stall_left;
    logic want_norm;
    push_expected();
    stall_left = stall_n;
    @(negedge clk);
    start = 1'b1;
    pif.prob_ready = 1'b1;
    cnt = 0; first_v = 0; done_at = 0;
    while (done_at == 0 && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      start = (cnt == extra_start);
      if (cnt == 1) begin
        chk({nm, "_busy_on_start"}, 64'(busy), 64'd1);
        chk({nm, "_norm_clear"}, 64'(norm_err), 64'd0);
      end
      if (pif.prob_valid && first_v == 0) first_v = cnt;
      if (done) done_at = cnt;
      if (pif.prob_valid && pif.prob_idx == 4'(stall_idx) && stall_left > 0) begin
        pif.prob_ready = 1'b0;
        stall_left--;
      end else pif.prob_ready = 1'b1;
    end
    chk({nm, "_first_valid_cycle"}, 64'(first_v), 64'(3));
    chk({nm, "_done_cycle"}, 64'(done_at), 64'(exp_done));
`ifdef READOUT_NORM_CHECK_EN
    want_norm = exp_norm;
`else
    want_norm = 1'b0;
`endif
    chk({nm, "_norm_err"}, 64'(norm_err), 64'(want_norm));
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_prob_sum"}, 64'(prob_sum), 64'(exp_sum));
    chk({nm, "_max_idx"}, 64'(max_idx), 64'(exp_max));
    chk({nm, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset_mid_run();
    int cnt;
    bit saw_done;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    pif.prob_ready = 1'b1;
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      start = 1'b0;
      if (pif.prob_valid && pif.prob_idx == 4'd8) break;
    end
    chk("rst_reached_word8", 64'(pif.prob_idx), 64'd8);
    pif.prob_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(pif.prob_valid), 64'd0);
    chk("rst_sum", 64'(prob_sum), 64'd0);
    chk("rst_max_idx", 64'(max_idx), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_words_left", 64'(exp_q.size()), 64'd8);
    exp_q.delete();
    rst_n = 1'b1;
    pif.prob_ready = 1'b1;
    saw_done = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || pif.prob_valid) saw_done = 1'b1;
    end
    chk("rst_no_done_or_words", 64'(saw_done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pif.prob_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(pif.prob_valid), 64'd0);
    chk("reset_sum", 64'(prob_sum), 64'd0);
    chk("reset_norm", 64'(norm_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basis |0>: 1.0 at index 0.
    clear_mem();
    mem_r[0] = 16'sd16384;
    do_run("t1_basis0", -1, 0, -1, 49, 36'd268435456, 4'd0, 1'b0);

    // H on q0: equal amplitudes at 0 and 1, tie keeps index 0.
    clear_mem();
    mem_r[0] = 16'sd11585;
    mem_r[1] = 16'sd11585;
    do_run("t2_hadamard", -1, 0, -1, 49, 36'd268424450, 4'd0, 1'b0);

    // Pure imaginary amplitude at index 5.
    clear_mem();
    mem_i[5] = -16'sd16384;
    do_run("t3_imag5", -1, 0, -1, 49, 36'd268435456, 4'd5, 1'b0);

    // Full-scale negative corner plus 7-cycle stall on word 3.
    clear_mem();
    mem_i[5] = -16'sd16384;
    mem_r[9] = -16'sd32768;
    mem_i[9] = -16'sd32768;
    mem_r[3] = 16'sd100;
    do_run("t4_corner_stall", 3, 7, -1, 56, 36'd2415929104, 4'd9, 1'b1);

    // All zero: total far from 1.0.
    clear_mem();
    do_run("t6_zero", -1, 0, -1, 49, 36'd0, 4'd0, 1'b1);

    // Start accepted after the flagged run clears the flag; exact norm stays clean.
    clear_mem();
    mem_r[0] = 16'sd16384;
    do_run("t6_clear", -1, 0, -1, 49, 36'd268435456, 4'd0, 1'b0);

    // Reset during word 8, then a fresh run with a stray start pulse while busy.
    clear_mem();
    mem_r[0] = 16'sd11585;
    mem_r[1] = 16'sd11585;
    do_reset_mid_run();
    do_run("t5_after_reset", -1, 0, 10, 49, 36'd268424450, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
